wb_dma_ram_mc: RTL and testbench
================================

WB_DMA_RAM_MC -- requirements
Module: wb_dma_ram_mc

Interface
REQ-001 SHALL have parameter NUM_OF_MEM_UNITS_TO_USE, default 1: memory depth in units of `MEMORY_UNIT_SIZE bits.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32: WB data width in bits (8, 16, 32 or 64).
REQ-003 SHALL have parameter CH_COUNT, default 2: number of raw DMA channels (1..8).
REQ-004 SHALL have parameter CH_DATA_WIDTH, default 8: raw channel data width (8..WB_DATA_WIDTH, power of two).
REQ-005 SHALL have derived parameters ADDR_WIDTH = clog2(memory bytes), SEL_WIDTH = WB_DATA_WIDTH/8 and CH_LANES = WB_DATA_WIDTH/CH_DATA_WIDTH.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, named wb_clk and wb_rst; port list:
- wb_clk  in  1  sole clock, all logic on rising edge
- wb_rst  in  1  asynchronous active-high reset
- wb_adr_i  in  ADDR_WIDTH  WB byte address
- wb_dat_i / wb_dat_o  in / out  WB_DATA_WIDTH  write / read data
- wb_sel_i  in  SEL_WIDTH  byte selects
- wb_we_i, wb_stb_i, wb_cyc_i  in  1  classic WB controls
- wb_ack_o  out  1  access done
- wb_err_o  out  1  out-of-range access (only with WB_DMA_RAM_ERR_EN)
- ch_req_i, ch_we_i  in  CH_COUNT  per-channel request / write
- ch_adr_i  in  CH_COUNT*ADDR_WIDTH  flattened byte addresses
- ch_dat_i / ch_dat_o  in / out  CH_COUNT*CH_DATA_WIDTH  flattened data
- ch_ack_o  out  CH_COUNT  per-channel done
- ch_err_o  out  CH_COUNT  per-channel out-of-range (only with WB_DMA_RAM_ERR_EN)

Function
REQ-007 SHALL hold one single-port array of WB_DATA_WIDTH words; at most one access per cycle.
REQ-008 SHALL arbitrate requesters {WB = index 0, ch0..chN-1 = 1..N} round-robin; pointer advances to one past the last granted index.
REQ-009 SHALL treat WB as requesting when wb_cyc_i & wb_stb_i & ~wb_ack_o, and channel k when ch_req_i[k] & ~ch_ack_o[k].
REQ-010 SHALL perform the granted access at the grant edge and pulse the matching ack for exactly one cycle the next cycle; latency 1 cycle uncontested, at most CH_COUNT+1 cycles under full load.
REQ-011 SHALL require requesters to hold address/data/we stable until ack; a request withdrawn before grant is simply dropped.
REQ-012 SHALL write WB bytes only where wb_sel_i is set; reads return the whole word regardless of sel.
REQ-013 SHALL map channel address to word = adr >> clog2(SEL_WIDTH) and lane = adr bits [clog2(SEL_WIDTH)-1 : clog2(CH_DATA_WIDTH/8)], ignoring the low sub-lane bits.
REQ-014 SHALL let channel writes modify only the selected lane; reads return that lane right-aligned on ch_dat_o.
REQ-015 SHALL hold each data output at its last read value until that requester's next completed read; writes leave it unchanged.
REQ-016 SHALL treat byte addresses >= memory bytes as out of range, never touching memory on such accesses.

Reset
REQ-017 SHALL drive on wb_rst: wb_ack_o=0, wb_err_o=0, ch_ack_o=0, ch_err_o=0, wb_dat_o=0, ch_dat_o=0, arbiter pointer=0.
REQ-018 SHALL discard in-flight grants on reset mid-operation (no ack produced), re-arbitrate still-held requests from pointer 0 after release, and leave memory contents unchanged.

Configuration
REQ-019 SHALL, with macro WB_DMA_RAM_ERR_EN defined, answer out-of-range accesses with a one-cycle wb_err_o / ch_err_o[k] pulse instead of ack, still consuming one arbitration slot.
REQ-020 SHALL, without WB_DMA_RAM_ERR_EN, tie wb_err_o and ch_err_o to 0, ack out-of-range accesses normally, and wrap addresses modulo memory size.

Structure
REQ-021 SHALL place shared constants (requester index WB=0, clog2 helpers) in package wb_dma_ram_pkg.
REQ-022 SHALL implement arbitration in sub-module rr_arbiter (parameter N, req in, one-hot grant out, pointer update on enable).

Verification
REQ-023 Reset: WB write 0xDEADBEEF at 0x10, sel=4'b1111 -> ack 1 cycle after stb; read 0x10 -> 0xDEADBEEF.
REQ-024 Lane write: ch0 (8-bit) writes 0xAA at 0x12 -> WB read 0x10 -> 0xDEAABEEF; ch1 read 0x13 -> 0xDE.
REQ-025 Contention: WB plus ch0 plus ch1 requesting on the same cycle from pointer 0 -> acks in order WB, ch0, ch1 on three consecutive cycles.
REQ-026 Fairness: ch0 requesting continuously, ch1 requesting once -> ch1 acked within 3 cycles, never starved.
REQ-027 Out-of-range with ERR_EN: WB write to address = memory bytes -> wb_err_o pulse, wb_ack_o=0, address 0 unchanged; without the macro -> ack, word 0 overwritten.
REQ-028 Reset mid-operation: assert wb_rst in the grant cycle -> no ack, outputs 0; held request acked 1 cycle after reset release.

Source files
------------

// File: rtl/wb_dma_ram_pkg.sv
// Shared constants and helpers for the multi-client WB/DMA RAM.
// MEMORY_UNIT_SIZE may be overridden on the command line.
`ifndef MEMORY_UNIT_SIZE
// Non-power-of-two byte count (192 B) so out-of-range addresses are reachable.
`define MEMORY_UNIT_SIZE 1536
`endif

package wb_dma_ram_pkg;
  localparam int REQ_WB      = 0;
  localparam int CH_REQ_BASE = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer one past the winner.
module rr_arbiter
  import wb_dma_ram_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? clog2(N) : 1;

  logic [PW-1:0] ptr, ptr_nxt;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                       = 1'b1;
        grant[(int'(ptr) + i) % N]  = 1'b1;
        ptr_nxt                     = PW'((int'(ptr) + i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/wb_dma_ram_mc.sv
// Single-port RAM shared by one Wishbone slave port and CH_COUNT raw DMA channels.
// Define WB_DMA_RAM_ERR_EN to answer out-of-range accesses with err instead of wrapping.
module wb_dma_ram_mc
  import wb_dma_ram_pkg::*;
#(
  parameter int  NUM_OF_MEM_UNITS_TO_USE = 1,
  parameter int  WB_DATA_WIDTH           = 32,
  parameter int  CH_COUNT                = 2,
  parameter int  CH_DATA_WIDTH           = 8,
  localparam int MEM_BYTES  = NUM_OF_MEM_UNITS_TO_USE * `MEMORY_UNIT_SIZE / 8,
  localparam int ADDR_WIDTH = clog2(MEM_BYTES),
  localparam int SEL_WIDTH  = WB_DATA_WIDTH / 8,
  localparam int CH_LANES   = WB_DATA_WIDTH / CH_DATA_WIDTH
) (
  input  logic                              wb_clk,
  input  logic                              wb_rst,
  input  logic [ADDR_WIDTH-1:0]             wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]          wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0]          wb_dat_o,
  input  logic [SEL_WIDTH-1:0]              wb_sel_i,
  input  logic                              wb_we_i,
  input  logic                              wb_stb_i,
  input  logic                              wb_cyc_i,
  output logic                              wb_ack_o,
  output logic                              wb_err_o,
  input  logic [CH_COUNT-1:0]               ch_req_i,
  input  logic [CH_COUNT-1:0]               ch_we_i,
  input  logic [CH_COUNT*ADDR_WIDTH-1:0]    ch_adr_i,
  input  logic [CH_COUNT*CH_DATA_WIDTH-1:0] ch_dat_i,
  output logic [CH_COUNT*CH_DATA_WIDTH-1:0] ch_dat_o,
  output logic [CH_COUNT-1:0]               ch_ack_o,
  output logic [CH_COUNT-1:0]               ch_err_o
);
  localparam int N         = CH_COUNT + 1;
  localparam int SB        = clog2(SEL_WIDTH);
  localparam int CB        = clog2(CH_DATA_WIDTH / 8);
  localparam int CH_BYTES  = CH_DATA_WIDTH / 8;
  localparam int MEM_WORDS = MEM_BYTES / SEL_WIDTH;
  localparam int WW        = ADDR_WIDTH - SB;
  localparam int LW        = (CH_LANES > 1) ? SB - CB : 1;
  localparam int AW1       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]  MB        = AW1'(MEM_BYTES);
  localparam logic [SEL_WIDTH-1:0] LANE_MASK = SEL_WIDTH'((1 << CH_BYTES) - 1);

  logic [N-1:0]                          req, grant, we_v, oor_v, ack_q;
  logic [N-1:0][ADDR_WIDTH-1:0]          raw_v, adr_v;
  logic [N-1:0][SEL_WIDTH-1:0]           mask_v;
  logic [N-1:0][WB_DATA_WIDTH-1:0]       wdat_v;
  logic [CH_COUNT-1:0][LW-1:0]           lane_v;
  logic [CH_COUNT-1:0][CH_DATA_WIDTH-1:0] ch_dat_q;
  logic [WB_DATA_WIDTH-1:0]              wb_dat_q, rd_word, acc_wdat;
  logic [WW-1:0]                         acc_word;
  logic [SEL_WIDTH-1:0]                  acc_mask;
  logic                                  acc_we, acc_oor;
  logic [WB_DATA_WIDTH-1:0]              mem [MEM_WORDS];

  // Addresses past the end fold back once; ADDR_WIDTH guarantees a < 2*MEM_BYTES.
  function automatic logic [ADDR_WIDTH-1:0] wrap(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] e;
    e = {1'b0, a};
    if (e >= MB) e = e - MB;
    return e[ADDR_WIDTH-1:0];
  endfunction

  assign req[REQ_WB]    = wb_cyc_i & wb_stb_i & ~ack_q[REQ_WB];
  assign we_v[REQ_WB]   = wb_we_i;
  assign raw_v[REQ_WB]  = wb_adr_i;
  assign mask_v[REQ_WB] = wb_sel_i;
  assign wdat_v[REQ_WB] = wb_dat_i;

  for (genvar k = 0; k < CH_COUNT; k++) begin : g_ch
    assign req[CH_REQ_BASE+k]   = ch_req_i[k] & ~ack_q[CH_REQ_BASE+k];
    assign we_v[CH_REQ_BASE+k]  = ch_we_i[k];
    assign raw_v[CH_REQ_BASE+k] = ch_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    if (CH_LANES > 1) begin : g_lane
      assign lane_v[k] = LW'(adr_v[CH_REQ_BASE+k] >> CB);
    end else begin : g_nolane
      assign lane_v[k] = '0;
    end
    assign mask_v[CH_REQ_BASE+k] = LANE_MASK << (lane_v[k] * CH_BYTES);
    assign wdat_v[CH_REQ_BASE+k] = {CH_LANES{ch_dat_i[k*CH_DATA_WIDTH +: CH_DATA_WIDTH]}};
  end

  for (genvar i = 0; i < N; i++) begin : g_adr
    assign adr_v[i] = wrap(raw_v[i]);
`ifdef WB_DMA_RAM_ERR_EN
    assign oor_v[i] = ({1'b0, raw_v[i]} >= MB);
`else
    assign oor_v[i] = 1'b0;
`endif
  end

  rr_arbiter #(.N(N)) u_arb (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .req   (req),
    .en    (|req),
    .grant (grant)
  );

  always_comb begin
    acc_we   = 1'b0;
    acc_oor  = 1'b0;
    acc_word = '0;
    acc_mask = '0;
    acc_wdat = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        acc_we   = we_v[i];
        acc_oor  = oor_v[i];
        acc_word = WW'(adr_v[i] >> SB);
        acc_mask = mask_v[i];
        acc_wdat = wdat_v[i];
      end
    end
  end

  assign rd_word = mem[acc_word];

  // Gated by reset so a grant discarded by reset never lands in memory.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst && (|grant) && acc_we && !acc_oor)
      for (int b = 0; b < SEL_WIDTH; b++)
        if (acc_mask[b]) mem[acc_word][b*8 +: 8] <= acc_wdat[b*8 +: 8];
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ack_q    <= '0;
      wb_dat_q <= '0;
      ch_dat_q <= '0;
    end else begin
      ack_q <= grant & ~oor_v;
      if (grant[REQ_WB] && !we_v[REQ_WB] && !oor_v[REQ_WB]) wb_dat_q <= rd_word;
      for (int k = 0; k < CH_COUNT; k++)
        if (grant[CH_REQ_BASE+k] && !we_v[CH_REQ_BASE+k] && !oor_v[CH_REQ_BASE+k])
          ch_dat_q[k] <= rd_word[lane_v[k]*CH_DATA_WIDTH +: CH_DATA_WIDTH];
    end
  end

`ifdef WB_DMA_RAM_ERR_EN
  logic [N-1:0] err_q;
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) err_q <= '0;
    else        err_q <= grant & oor_v;
  end
  assign wb_err_o = err_q[REQ_WB];
  assign ch_err_o = err_q[N-1:CH_REQ_BASE];
`else
  assign wb_err_o = 1'b0;
  assign ch_err_o = '0;
`endif

  assign wb_ack_o = ack_q[REQ_WB];
  assign ch_ack_o = ack_q[N-1:CH_REQ_BASE];
  assign wb_dat_o = wb_dat_q;
  assign ch_dat_o = ch_dat_q;
endmodule

// File: tb/tb_wb_dma_ram_mc.sv
// Directed bench for wb_dma_ram_mc at default parameters (192-byte memory,
// 32-bit WB, two 8-bit channels); expectations follow WB_DMA_RAM_ERR_EN if defined.
module tb_wb_dma_ram_mc;
  localparam int AW = 8;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [AW-1:0] wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o;
  logic [1:0]  ch_req_i, ch_we_i, ch_ack_o, ch_err_o;
  logic [15:0] ch_adr_i, ch_dat_i, ch_dat_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 wb_clk = ~wb_clk;

  wb_dma_ram_mc dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .ch_req_i (ch_req_i),
    .ch_we_i  (ch_we_i),
    .ch_adr_i (ch_adr_i),
    .ch_dat_i (ch_dat_i),
    .ch_dat_o (ch_dat_o),
    .ch_ack_o (ch_ack_o),
    .ch_err_o (ch_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Returns cycles from request to response (-1 on timeout) and {err, ack} seen.
  task automatic wb_xfer(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat, output logic [1:0] flg);
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    lat = -1; flg = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge wb_clk);
      if (wb_ack_o || wb_err_o) begin
        lat = c; flg = {wb_err_o, wb_ack_o};
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic ch_xfer(input int k, input logic we, input logic [AW-1:0] adr,
                         input logic [7:0] dat, output int lat, output logic [1:0] flg);
    @(negedge wb_clk);
    ch_req_i[k] = 1'b1; ch_we_i[k] = we;
    ch_adr_i[k*8 +: 8] = adr; ch_dat_i[k*8 +: 8] = dat;
    lat = -1; flg = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge wb_clk);
      if (ch_ack_o[k] || ch_err_o[k]) begin
        lat = c; flg = {ch_err_o[k], ch_ack_o[k]};
        break;
      end
    end
    ch_req_i[k] = 1'b0; ch_we_i[k] = 1'b0;
  endtask

  initial begin
    int lat, t_wb, t0, t1, n0;
    logic [1:0] flg;

    wb_rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    ch_req_i = '0; ch_we_i = '0; ch_adr_i = '0; ch_dat_i = '0;
    repeat (3) @(negedge wb_clk);
    chk("rst_flags", {wb_ack_o, wb_err_o, ch_ack_o, ch_err_o}, 0);
    chk("rst_wb_dat", wb_dat_o, 0);
    chk("rst_ch_dat", ch_dat_o, 0);
    wb_rst = 1'b0;

    // Full-word write then read back
    wb_xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat, flg);
    chk("wr_lat", lat, 1);
    chk("wr_flg", flg, 2'b01);
    chk("wr_keeps_dat", wb_dat_o, 0);
    wb_xfer(1'b0, 8'h10, 32'h0, 4'h0, lat, flg);
    chk("rd_lat", lat, 1);
    chk("rd_dat", wb_dat_o, 32'hDEADBEEF);

    // Channel lane write, WB sees only byte 2 replaced
    ch_xfer(0, 1'b1, 8'h12, 8'hAA, lat, flg);
    chk("ch0_wr_lat", lat, 1);
    chk("ch0_wr_keeps", ch_dat_o, 0);
    wb_xfer(1'b0, 8'h10, 32'h0, 4'hF, lat, flg);
    chk("lane_merge", wb_dat_o, 32'hDEAABEEF);

    // Partial WB write with sel=0011
    wb_xfer(1'b1, 8'h10, 32'h11223344, 4'b0011, lat, flg);
    chk("wr_sel_hold", wb_dat_o, 32'hDEAABEEF);
    wb_xfer(1'b0, 8'h10, 32'h0, 4'h0, lat, flg);
    chk("rd_sel", wb_dat_o, 32'hDEAA3344);

    // ch1 top-byte read; last grant index 2 puts the pointer back to 0
    ch_xfer(1, 1'b0, 8'h13, 8'h00, lat, flg);
    chk("ch1_rd_lat", lat, 1);
    chk("ch1_rd", ch_dat_o, 16'hDE00);

    // Three-way contention from pointer 0
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h10;
    ch_req_i = 2'b11; ch_we_i = 2'b00; ch_adr_i = {8'h11, 8'h10};
    t_wb = -1; t0 = -1; t1 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge wb_clk);
      if (wb_ack_o)    begin t_wb = c; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      if (ch_ack_o[0]) begin t0 = c; ch_req_i[0] = 1'b0; end
      if (ch_ack_o[1]) begin t1 = c; ch_req_i[1] = 1'b0; end
    end
    chk("cont_wb_cyc", t_wb, 1);
    chk("cont_ch0_cyc", t0, 2);
    chk("cont_ch1_cyc", t1, 3);
    chk("cont_wb_dat", wb_dat_o, 32'hDEAA3344);
    chk("cont_ch_dat", ch_dat_o, 16'h3344);

    // Fairness: ch0 hammers, ch1 asks once
    @(negedge wb_clk);
    ch_req_i[0] = 1'b1; ch_we_i[0] = 1'b0; ch_adr_i[7:0] = 8'h10;
    n0 = 0;
    repeat (2) begin @(negedge wb_clk); if (ch_ack_o[0]) n0++; end
    ch_req_i[1] = 1'b1; ch_we_i[1] = 1'b0; ch_adr_i[15:8] = 8'h13;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge wb_clk);
      if (ch_ack_o[0]) n0++;
      if (ch_ack_o[1] && lat < 0) begin lat = c; ch_req_i[1] = 1'b0; end
    end
    ch_req_i = 2'b00;
    repeat (2) @(negedge wb_clk);
    chk("fair_ch1_lat", (lat >= 1 && lat <= 3), 1);
    chk("fair_ch0_served", (n0 >= 3), 1);
    chk("fair_dat", ch_dat_o, 16'hDE44);

    // Out-of-range access at address == memory bytes (192)
    wb_xfer(1'b1, 8'h00, 32'h01020304, 4'hF, lat, flg);
    wb_xfer(1'b1, 8'hC0, 32'hCAFEF00D, 4'hF, lat, flg);
    chk("oor_lat", lat, 1);
`ifdef WB_DMA_RAM_ERR_EN
    chk("oor_flg", flg, 2'b10);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'h0, lat, flg);
    chk("oor_word0", wb_dat_o, 32'h01020304);
    ch_xfer(0, 1'b0, 8'hC1, 8'h00, lat, flg);
    chk("oor_ch_flg", flg, 2'b10);
    chk("oor_ch_dat", ch_dat_o[7:0], 8'h44);
`else
    chk("oor_flg", flg, 2'b01);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'h0, lat, flg);
    chk("oor_word0", wb_dat_o, 32'hCAFEF00D);
    ch_xfer(0, 1'b0, 8'hC1, 8'h00, lat, flg);
    chk("oor_ch_flg", flg, 2'b01);
    chk("oor_ch_dat", ch_dat_o[7:0], 8'hF0);
`endif

    // Reset asserted during the grant cycle of a held read
    @(negedge wb_clk);
    wb_rst = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h10;
    @(negedge wb_clk);
    chk("mid_rst_ack", {wb_ack_o, wb_err_o}, 0);
    chk("mid_rst_dat", {wb_dat_o, ch_dat_o}, 0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("post_rst_ack", wb_ack_o, 1);
    chk("post_rst_dat", wb_dat_o, 32'hDEAA3344);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
